// File: rtl/snn_debug_pkg.sv
// snn_debug_pkg: shared mode/state encodings and cfg field layout for snn_debug_probe
package snn_debug_pkg;
  localparam int CFG_MODE_W = 2;
  localparam int CFG_IDX_W = 6;
  typedef enum logic [CFG_MODE_W-1:0] {
    MODE_LIVE    = 2'b00,
    MODE_SCAN    = 2'b01,
    MODE_CAPTURE = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;
  typedef enum logic [1:0] {FILL, DRAIN, DONE} cap_state_t;
  typedef struct packed {
    mode_t                mode;
    logic [CFG_IDX_W-1:0] idx;
  } cfg_t;
endpackage

// File: rtl/snn_debug_probe_if.sv
// snn_debug_probe_if: config/data/debug bundle; master drives cfg and layer data, slave is the probe
interface snn_debug_probe_if #(
  parameter int N_MEM = 18,
  parameter int MEM_W = 5,
  parameter int N_SPK = 3,
  parameter int SPK_W = 8,
  parameter int OUT_W = 8
);
  logic                   en;
  logic [7:0]             cfg_in;
  logic                   step;
  logic [N_MEM*MEM_W-1:0] membrane_potentials;
  logic [N_SPK*SPK_W-1:0] spikes;
  logic [OUT_W-1:0]       debug_output;
  logic                   debug_valid;
  logic                   capture_done;
  modport master(output en, cfg_in, step, membrane_potentials, spikes,
                 input debug_output, debug_valid, capture_done);
  modport slave(input en, cfg_in, step, membrane_potentials, spikes,
                output debug_output, debug_valid, capture_done);
endinterface

// File: rtl/snn_debug_capture_buf.sv
// snn_debug_capture_buf: DEPTH x OUT_W capture buffer with FILL/DRAIN/DONE FSM; ports clk, rst (async), clr, wr_en, din -> data, valid, done
module snn_debug_capture_buf
  import snn_debug_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] data,
  output logic             valid,
  output logic             done
);
  localparam int PW = $clog2(DEPTH);
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  cap_state_t state;
  always_ff @(posedge clk)
    if (state == FILL && wr_en) mem[wr] <= din;
  // The final write already presents entry 0, so the first drain beat lands the next cycle;
  // rd then walks 1..DEPTH-1 and its wrap to 0 marks the end of the drain.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      wr    <= '0;
      rd    <= '0;
      data  <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (clr) begin
      state <= FILL;
      wr    <= '0;
      rd    <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        FILL:
          if (wr_en) begin
            wr <= wr + 1'b1;
            if (wr == PW'(DEPTH - 1)) begin
              state <= DRAIN;
              data  <= mem[0];
              valid <= 1'b1;
              rd    <= PW'(1);
            end
          end
        DRAIN:
          if (rd == '0) begin
            state <= DONE;
            valid <= 1'b0;
            done  <= 1'b1;
          end else begin
            data <= mem[rd];
            rd   <= rd + 1'b1;
          end
        default: ;
      endcase
    end
endmodule

// File: rtl/snn_debug_probe.sv
// snn_debug_probe: debug channel mux with live/scan/capture/hold modes; ports clk, rst (async), io (slave); capture buffer built only with DEBUG_CAPTURE_EN
module snn_debug_probe
  import snn_debug_pkg::*;
#(
  parameter int N_MEM = 18,
  parameter int MEM_W = 5,
  parameter int N_SPK = 3,
  parameter int SPK_W = 8,
  parameter int OUT_W = 8,
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  snn_debug_probe_if.slave  io
);
  localparam int N_CH = N_MEM + N_SPK;
  function automatic logic [OUT_W-1:0] chan(input logic [CFG_IDX_W-1:0] idx,
                                            input logic [N_MEM*MEM_W-1:0] mp,
                                            input logic [N_SPK*SPK_W-1:0] sp);
    int i;
    i = int'(idx);
    return i < N_MEM ? OUT_W'(mp[i*MEM_W +: MEM_W]) :
           i < N_CH  ? OUT_W'(sp[(i-N_MEM)*SPK_W +: SPK_W]) : '0;
  endfunction
  cfg_t cfg;
  logic [CFG_IDX_W-1:0] scan_idx, load_idx;
  logic [OUT_W-1:0] dout, live_val, scan_val, cap_data;
  logic dvalid, cap_valid, cap_done, step_ok, cap_sel;
  assign live_val = chan(cfg.idx, io.membrane_potentials, io.spikes);
  assign scan_val = chan(scan_idx, io.membrane_potentials, io.spikes);
  assign load_idx = io.cfg_in[CFG_IDX_W-1:0] < CFG_IDX_W'(N_CH) ? io.cfg_in[CFG_IDX_W-1:0] : '0;
  // a cfg load on the same cycle as step swallows that step
  assign step_ok = io.step & ~io.en;
`ifdef DEBUG_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
  snn_debug_capture_buf #(.OUT_W(OUT_W), .DEPTH(DEPTH)) u_cap (
    .clk  (clk),
    .rst  (rst),
    .clr  (io.en),
    .wr_en(step_ok && cfg.mode == MODE_CAPTURE),
    .din  (live_val),
    .data (cap_data),
    .valid(cap_valid),
    .done (cap_done)
  );
`else
  // without the buffer DEPTH has no role; every legal DEPTH (>= 2) leaves capture off
  localparam bit CAP_EN = DEPTH < 2;
  assign cap_data  = '0;
  assign cap_valid = 1'b0;
  assign cap_done  = 1'b0;
`endif
  assign cap_sel         = CAP_EN && cfg.mode == MODE_CAPTURE;
  assign io.debug_output = cap_sel ? cap_data : dout;
  assign io.debug_valid  = cap_sel ? cap_valid : dvalid;
  assign io.capture_done = cap_done;
  // In capture mode dout shadows the buffer output so a later HOLD freezes what was last shown.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cfg      <= '0;
      scan_idx <= '0;
      dout     <= '0;
      dvalid   <= 1'b0;
    end else begin
      if (io.en) begin
        cfg      <= cfg_t'(io.cfg_in);
        scan_idx <= load_idx;
      end else if (step_ok && cfg.mode == MODE_SCAN)
        scan_idx <= scan_idx == CFG_IDX_W'(N_CH - 1) ? '0 : scan_idx + 1'b1;
      case (cfg.mode)
        MODE_SCAN: begin
          dvalid <= step_ok;
          if (step_ok) dout <= scan_val;
        end
        MODE_HOLD: dvalid <= 1'b0;
        MODE_CAPTURE: begin
          dout   <= CAP_EN ? cap_data : live_val;
          dvalid <= !CAP_EN;
        end
        default: begin
          dout   <= live_val;
          dvalid <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_snn_debug_probe.sv
// tb_snn_debug_probe: scoreboard bench for snn_debug_probe; capture scenarios follow DEBUG_CAPTURE_EN
module tb_snn_debug_probe;
  import snn_debug_pkg::*;
  localparam int N_MEM = 18, MEM_W = 5, N_SPK = 3, SPK_W = 8, OUT_W = 8, DEPTH = 8;
  localparam int N_CH = N_MEM + N_SPK;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  snn_debug_probe_if #(.N_MEM(N_MEM), .MEM_W(MEM_W), .N_SPK(N_SPK), .SPK_W(SPK_W), .OUT_W(OUT_W)) io_if ();
  snn_debug_probe #(.N_MEM(N_MEM), .MEM_W(MEM_W), .N_SPK(N_SPK), .SPK_W(SPK_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .io (io_if.slave)
  );
  logic [MEM_W-1:0] mv [N_MEM];
  logic [SPK_W-1:0] sv [N_SPK];
  for (genvar g = 0; g < N_MEM; g++) begin : g_mp
    assign io_if.membrane_potentials[g*MEM_W +: MEM_W] = mv[g];
  end
  for (genvar g = 0; g < N_SPK; g++) begin : g_sp
    assign io_if.spikes[g*SPK_W +: SPK_W] = sv[g];
  end
  int checks = 0;
  int fails = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] e;

  function automatic logic [OUT_W-1:0] ref_chan(input int idx);
    if (idx < N_MEM) return {{(OUT_W-MEM_W){1'b0}}, mv[idx]};
    if (idx < N_CH) return sv[idx-N_MEM];
    return '0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    io_if.en = 1'b1;
    io_if.cfg_in = v;
    cyc();
    io_if.en = 1'b0;
  endtask

  task automatic step_pulse();
    io_if.step = 1'b1;
    cyc();
    io_if.step = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io_if.en = 1'b0;
    io_if.step = 1'b0;
    io_if.cfg_in = '0;
    for (int k = 0; k < N_MEM; k++) mv[k] = MEM_W'($urandom);
    for (int k = 0; k < N_SPK; k++) sv[k] = SPK_W'($urandom);
    mv[0] = 5'h0D;
    #3;
    checks++; if (io_if.debug_output !== 8'h00) begin fails++; $display("FAIL reset_out: got %h expected 00", io_if.debug_output); end
    checks++; if (io_if.debug_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", io_if.debug_valid); end
    checks++; if (io_if.capture_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", io_if.capture_done); end
    repeat (2) cyc();
    rst = 1'b0;
    exp_q.push_back(8'h0D);
    cyc();
    e = exp_q.pop_front();
    checks++; if (io_if.debug_output !== e) begin fails++; $display("FAIL reset_live_ch0: got %h expected %h", io_if.debug_output, e); end
    checks++; if (io_if.debug_valid !== 1'b1) begin fails++; $display("FAIL reset_live_valid: got %b expected 1", io_if.debug_valid); end
  endtask

  task automatic test_live();
    int idx_tab[6] = '{3, 19, 40, 20, 0, 17};
    mv[3] = 5'b10110;
    sv[1] = 8'hA5;
    sv[2] = 8'h3C;
    for (int t = 0; t < 6; t++) begin
      exp_q.push_back(ref_chan(idx_tab[t]));
      load({MODE_LIVE, 6'(idx_tab[t])});
      cyc();
      e = exp_q.pop_front();
      checks++; if (io_if.debug_output !== e) begin fails++; $display("FAIL live_idx%0d: got %h expected %h", idx_tab[t], io_if.debug_output, e); end
      checks++; if (io_if.debug_valid !== 1'b1) begin fails++; $display("FAIL live_valid_idx%0d: got %b expected 1", idx_tab[t], io_if.debug_valid); end
    end
    load({MODE_LIVE, 6'd3});
    cyc();
    mv[3] = 5'h09;
    exp_q.push_back(8'h09);
    cyc();
    e = exp_q.pop_front();
    checks++; if (io_if.debug_output !== e) begin fails++; $display("FAIL live_latency: got %h expected %h", io_if.debug_output, e); end
  endtask

  task automatic test_scan();
    mv[0] = 5'h11;
    load({MODE_SCAN, 6'd19});
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ref_chan((19 + k) % N_CH));
      step_pulse();
      e = exp_q.pop_front();
      checks++; if (io_if.debug_valid !== 1'b1 || io_if.debug_output !== e) begin fails++; $display("FAIL scan_step%0d: got valid=%b data=%h expected valid=1 data=%h", k, io_if.debug_valid, io_if.debug_output, e); end
      cyc();
      checks++; if (io_if.debug_valid !== 1'b0) begin fails++; $display("FAIL scan_pulse%0d: got valid=%b expected 0", k, io_if.debug_valid); end
    end
    load({MODE_SCAN, 6'd40});
    exp_q.push_back(ref_chan(0));
    step_pulse();
    e = exp_q.pop_front();
    checks++; if (io_if.debug_valid !== 1'b1 || io_if.debug_output !== e) begin fails++; $display("FAIL scan_oob_start: got valid=%b data=%h expected valid=1 data=%h", io_if.debug_valid, io_if.debug_output, e); end
    io_if.en = 1'b1;
    io_if.cfg_in = {MODE_SCAN, 6'd5};
    io_if.step = 1'b1;
    cyc();
    io_if.en = 1'b0;
    io_if.step = 1'b0;
    checks++; if (io_if.debug_valid !== 1'b0) begin fails++; $display("FAIL scan_en_step: got valid=%b expected 0", io_if.debug_valid); end
    exp_q.push_back(ref_chan(5));
    step_pulse();
    e = exp_q.pop_front();
    checks++; if (io_if.debug_output !== e) begin fails++; $display("FAIL scan_after_load: got %h expected %h", io_if.debug_output, e); end
  endtask

`ifdef DEBUG_CAPTURE_EN
  task automatic test_capture();
    load({MODE_CAPTURE, 6'd3});
    for (int s = 1; s <= DEPTH; s++) begin
      mv[3] = MEM_W'(s);
      exp_q.push_back(OUT_W'(s));
      step_pulse();
      if (s < DEPTH) begin
        checks++; if (io_if.debug_valid !== 1'b0) begin fails++; $display("FAIL fill_valid%0d: got %b expected 0", s, io_if.debug_valid); end
      end
    end
    for (int b = 0; b < DEPTH; b++) begin
      e = exp_q.pop_front();
      checks++; if (io_if.debug_valid !== 1'b1 || io_if.debug_output !== e) begin fails++; $display("FAIL drain_beat%0d: got valid=%b data=%h expected valid=1 data=%h", b, io_if.debug_valid, io_if.debug_output, e); end
      cyc();
    end
    checks++; if (io_if.capture_done !== 1'b1) begin fails++; $display("FAIL capture_done: got %b expected 1", io_if.capture_done); end
    checks++; if (io_if.debug_valid !== 1'b0 || io_if.debug_output !== 8'(DEPTH)) begin fails++; $display("FAIL done_hold: got valid=%b data=%h expected valid=0 data=%h", io_if.debug_valid, io_if.debug_output, 8'(DEPTH)); end
  endtask

  task automatic test_back_to_back();
    io_if.en = 1'b1;
    io_if.cfg_in = {MODE_CAPTURE, 6'd3};
    io_if.step = 1'b1;
    mv[3] = 5'd30;
    cyc();
    io_if.en = 1'b0;
    io_if.step = 1'b0;
    checks++; if (io_if.capture_done !== 1'b0) begin fails++; $display("FAIL reload_done: got %b expected 0", io_if.capture_done); end
    for (int s = 0; s < DEPTH; s++) begin
      mv[3] = MEM_W'(11 + s);
      exp_q.push_back(OUT_W'(11 + s));
      step_pulse();
    end
    for (int b = 0; b < DEPTH; b++) begin
      e = exp_q.pop_front();
      checks++; if (io_if.debug_valid !== 1'b1 || io_if.debug_output !== e) begin fails++; $display("FAIL restart_beat%0d: got valid=%b data=%h expected valid=1 data=%h", b, io_if.debug_valid, io_if.debug_output, e); end
      cyc();
    end
    checks++; if (io_if.capture_done !== 1'b1) begin fails++; $display("FAIL restart_done: got %b expected 1", io_if.capture_done); end
  endtask
`else
  task automatic test_mode10_live();
    mv[3] = 5'h1A;
    exp_q.push_back(8'h1A);
    load({MODE_CAPTURE, 6'd3});
    cyc();
    e = exp_q.pop_front();
    checks++; if (io_if.debug_output !== e || io_if.debug_valid !== 1'b1) begin fails++; $display("FAIL mode10_live: got valid=%b data=%h expected valid=1 data=%h", io_if.debug_valid, io_if.debug_output, e); end
    for (int s = 0; s < DEPTH + 2; s++) begin
      mv[3] = MEM_W'(s);
      step_pulse();
    end
    exp_q.push_back(OUT_W'(DEPTH + 1));
    e = exp_q.pop_front();
    checks++; if (io_if.debug_output !== e || io_if.debug_valid !== 1'b1) begin fails++; $display("FAIL mode10_track: got valid=%b data=%h expected valid=1 data=%h", io_if.debug_valid, io_if.debug_output, e); end
    checks++; if (io_if.capture_done !== 1'b0) begin fails++; $display("FAIL mode10_done: got %b expected 0", io_if.capture_done); end
  endtask
`endif

  task automatic test_hold();
    mv[3] = 5'h0B;
    load({MODE_LIVE, 6'd3});
    cyc();
    exp_q.push_back(8'h0B);
    load({MODE_HOLD, 6'd0});
    mv[3] = 5'h1F;
    repeat (3) cyc();
    e = exp_q.pop_front();
    checks++; if (io_if.debug_output !== e) begin fails++; $display("FAIL hold_out: got %h expected %h", io_if.debug_output, e); end
    checks++; if (io_if.debug_valid !== 1'b0) begin fails++; $display("FAIL hold_valid: got %b expected 0", io_if.debug_valid); end
  endtask

  task automatic test_reset_mid();
    load({MODE_CAPTURE, 6'd3});
    for (int s = 0; s < 3; s++) step_pulse();
    rst = 1'b1;
    #2;
    checks++; if (io_if.debug_output !== 8'h00 || io_if.debug_valid !== 1'b0 || io_if.capture_done !== 1'b0) begin fails++; $display("FAIL mid_reset: got data=%h valid=%b done=%b expected 00 0 0", io_if.debug_output, io_if.debug_valid, io_if.capture_done); end
    cyc();
    rst = 1'b0;
    mv[0] = 5'h07;
    exp_q.push_back(8'h07);
    cyc();
    e = exp_q.pop_front();
    checks++; if (io_if.debug_output !== e || io_if.debug_valid !== 1'b1) begin fails++; $display("FAIL mid_reset_live: got valid=%b data=%h expected valid=1 data=%h", io_if.debug_valid, io_if.debug_output, e); end
  endtask

  initial begin
    test_reset();
    test_live();
    test_scan();
`ifdef DEBUG_CAPTURE_EN
    test_capture();
    test_back_to_back();
`else
    test_mode10_live();
`endif
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
